// File: rtl/serial_paralelo_idl_rx_if.sv
// Bus bundle for the IDL link receiver: serial bit in, payload byte and link
// status out. The DUT side uses the master modport, a consumer uses slave.
// Optional macro: SP_RX_ERRCNT_EN adds the err_cnt status byte.
interface serial_paralelo_idl_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       IDL;
`ifdef SP_RX_ERRCNT_EN
  logic [7:0] err_cnt;

  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output IDL,
    output err_cnt
  );

  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  IDL,
    input  err_cnt
  );
`else
  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output IDL
  );

  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  IDL
  );
`endif
endinterface

// File: rtl/serial_paralelo_idl_rx.sv
// Receive end of the parallel-serial IDL link. Deserializes the MSB-first bit
// stream into bytes, locks byte alignment on a run of comma symbols, strips
// comma/idle fill and strobes payload bytes out with a one-cycle valid.
// Optional macro: SP_RX_ERRCNT_EN adds a saturating count of alignment aborts
// and link losses on bus.err_cnt.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SEARCH  | sliding compare of every bit position against COMMA
// ST_ALIGNED | byte boundary fixed, counting consecutive commas to lock
// ST_ACTIVE  | link up: payload strobed, commas dropped, idles counted
module serial_paralelo_idl_rx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDL_SYM     = 8'h7C,
  parameter int unsigned ALIGN_COUNT = 4,
  parameter int unsigned IDL_LOSS    = 4
) (
  input logic                      clk_32f,
  input logic                      reset,
  serial_paralelo_idl_rx_if.master bus
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ALIGNED = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  localparam logic [3:0] ALIGN_LIM = 4'(ALIGN_COUNT);
  localparam logic [3:0] IDL_LIM   = 4'(IDL_LOSS);

  logic [1:0] state;
  // Only the seven most recent bits are ever needed: the eighth is data_in.
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [3:0] idl_cnt;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;
  logic       idl_q;

  logic [7:0] cand;
  logic       at_boundary;
  logic       is_comma;
  logic       is_idle;
  logic [3:0] bc_next;
  logic [3:0] idl_next;
  logic       align_abort;
  logic       link_loss;

  assign cand        = {sr, bus.data_in};
  assign at_boundary = (bit_cnt == 3'd7);
  assign is_comma    = (cand == COMMA);
  assign is_idle     = (cand == IDL_SYM);

  // Counters stop at their maximum instead of wrapping.
  assign bc_next  = (bc_cnt  == 4'hF) ? bc_cnt  : bc_cnt  + 4'd1;
  assign idl_next = (idl_cnt == 4'hF) ? idl_cnt : idl_cnt + 4'd1;

  assign align_abort = (state == ST_ALIGNED) && at_boundary && !is_comma;
  assign link_loss   = (state == ST_ACTIVE) && at_boundary && !is_comma &&
                       is_idle && (idl_next >= IDL_LIM);

  // Shift register that supplies the candidate byte.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr <= 7'd0;
    end else begin
      sr <= {sr[5:0], bus.data_in};
    end
  end

  // Alignment / link FSM with payload extraction.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= ST_SEARCH;
      bit_cnt  <= 3'd0;
      bc_cnt   <= 4'd0;
      idl_cnt  <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      idl_q    <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_SEARCH: begin
          bit_cnt <= 3'd0;
          if (is_comma) begin
            bc_cnt  <= 4'd1;
            idl_cnt <= 4'd0;
            if (ALIGN_LIM <= 4'd1) begin
              state    <= ST_ACTIVE;
              active_q <= 1'b1;
              idl_q    <= 1'b0;
            end else begin
              state <= ST_ALIGNED;
            end
          end
        end

        ST_ALIGNED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (at_boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_next;
              if (bc_next >= ALIGN_LIM) begin
                state    <= ST_ACTIVE;
                active_q <= 1'b1;
                idl_q    <= 1'b0;
                idl_cnt  <= 4'd0;
              end
            end else begin
              // The rejected byte is not rescanned; sliding search restarts
              // with the next bit.
              state   <= ST_SEARCH;
              bc_cnt  <= 4'd0;
              bit_cnt <= 3'd0;
            end
          end
        end

        ST_ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (at_boundary) begin
            if (is_comma) begin
              idl_cnt <= 4'd0;
            end else if (is_idle) begin
              idl_cnt <= idl_next;
              if (idl_next >= IDL_LIM) begin
                state    <= ST_SEARCH;
                active_q <= 1'b0;
                idl_q    <= 1'b1;
                bc_cnt   <= 4'd0;
                bit_cnt  <= 3'd0;
                idl_cnt  <= 4'd0;
              end
            end else begin
              data_q  <= cand;
              valid_q <= 1'b1;
              idl_cnt <= 4'd0;
            end
          end
        end

        default: begin
          state    <= ST_SEARCH;
          bit_cnt  <= 3'd0;
          bc_cnt   <= 4'd0;
          idl_cnt  <= 4'd0;
          active_q <= 1'b0;
          idl_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;
  assign bus.IDL       = idl_q;

`ifdef SP_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of alignment aborts and link losses; one per edge at most.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else if ((align_abort || link_loss) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = align_abort ^ link_loss;
`endif

endmodule

// File: doc/serial_paralelo_idl_rx.md
Name: serial_paralelo_idl_rx

Overview:
- Receive end of the parallel-serial IDL link: deserializes the 1-bit stream at clk_32f into bytes.
- Locks byte alignment on the comma symbol 0xBC and asserts `active` after a run of consecutive commas.
- Strips comma and IDL fill symbols, then presents payload bytes with a one-cycle valid strobe.
- Sits between the serial line and the parallel-side FIFO/demux logic.

Parameters:
- COMMA, 8'hBC, alignment/fill symbol.
- IDL_SYM, 8'h7C, idle symbol the transmitter sends when inactive.
- ALIGN_COUNT, 4, consecutive aligned commas needed to assert `active` (range 1..15).
- IDL_LOSS, 4, consecutive IDL_SYM bytes that drop `active` (range 1..15).

Ports:
- clk_32f  input  1  bit clock; the only clock. Sync reset, active-high.
- reset  input  1  synchronous, active-high.
- data_in  input  1  serial bit, MSB first, sampled on rising clk_32f.
- data_out  output  8  last payload byte received.
- valid_out  output  1  one-cycle strobe, data_out is new.
- active  output  1  link aligned and carrying traffic.
- IDL  output  1  high when `active`=0 (link idle/unaligned).

Behaviour:
- Reset values, applied on any clock edge with reset=1, including mid-byte: state=SEARCH, sr=0, bit_cnt=0, bc_cnt=0, idl_cnt=0, data_out=8'h00, valid_out=0, active=0, IDL=1.
- Every non-reset edge: sr <= {sr[6:0], data_in}. The candidate byte is cand = {sr[6:0], data_in}.
- SEARCH:
  - Compare cand to COMMA every cycle (sliding alignment).
  - On match: go to ALIGNED, bit_cnt=0, bc_cnt=1.
  - If ALIGN_COUNT=1, go directly to ACTIVE instead.
- ALIGNED:
  - bit_cnt increments 0..7 and wraps 7→0. A byte boundary is the edge where bit_cnt==7.
  - At a boundary with cand==COMMA: bc_cnt++. When bc_cnt reaches ALIGN_COUNT, go to ACTIVE.
  - At a boundary with any other byte: go to SEARCH with bc_cnt=0. That byte is not searched for an embedded comma; the sliding search resumes on the next edge.
- ACTIVE (active=1, IDL=0, registered; both update on the transition edge):
  - At each boundary, if cand==COMMA: fill. valid_out=0, idl_cnt=0.
  - If cand==IDL_SYM: idl_cnt++, valid_out=0. When idl_cnt reaches IDL_LOSS, go to SEARCH, active=0, IDL=1, bc_cnt=0.
  - Any other value: data_out<=cand, valid_out=1 for exactly one cycle, idl_cnt=0.
- Latency: data_out/valid_out update on the edge that samples the byte's LSB, so they are visible the cycle after the last bit is presented.
- valid_out is 0 on every non-boundary cycle. Maximum strobe rate is one per 8 clocks.
- data_out holds its value between strobes and is never cleared except by reset.
- A comma arriving at a mis-aligned offset while ACTIVE is not detected; alignment is only re-acquired via SEARCH.
- Counters saturate at their limits and never wrap.

Optional Feature:
- Macro: SP_RX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset to 0.
  - Increments by 1 (saturating at 8'hFF) on each ALIGNED→SEARCH abort and each ACTIVE→SEARCH loss.
  - If both events fall on the same edge, it counts once.
- Not defined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset mid-stream: drive reset=1 for 1 edge while ACTIVE → next cycle active=0, IDL=1, data_out=8'h00, valid_out=0.
- Alignment: send 3 random bits then 4×8'hBC → active rises on the edge sampling the LSB of the 4th 0xBC; no valid_out during the preamble.
- Payload: after lock, send 0xBC, 0x5A, 0xBC, 0xFF, 0x00 → valid_out pulses 3 times, with data_out 0x5A, 0xFF, 0x00, each visible 1 cycle after its last bit; data_out holds 0x5A during the following 0xBC.
- Alignment abort: send 2×0xBC then 0x12 → stays SEARCH/active=0. A following 4×0xBC then locks. With SP_RX_ERRCNT_EN, err_cnt=1.
- Link loss: while ACTIVE send 3×0x7C, 0x33, 4×0x7C → 0x33 strobed once; active falls on the LSB edge of the 4th consecutive 0x7C; IDL=1.
- Data-vs-fill: while ACTIVE send 0x7C, 0xBC, 0x7C ×3 → idl_cnt reset by the comma, active stays 1 (never reaches 4).
